fir_frame_packer: RTL

- Downstream consumer of the polyphase decimating FIR output.
- Captures a fixed-length frame of decimated signed samples, starting at a chirp-start trigger, into a small internal sample FIFO.
- Serialises each frame to a byte stream over a valid/ready handshake, for the host-link FIFO (FT245-style writer).
- Each frame is a start-flag byte, then two bytes per sample (MSB byte first), then one footer byte that carries overflow status.

---
 rtl/fir_frame_packer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fir_frame_packer.sv
// Purpose: captures a fixed-length frame of decimated FIR samples into a small FIFO and
//          serialises it as start-flag byte, MSB/LSB byte pairs per sample, then a footer byte.
// Latency: header byte valid the cycle after an accepted chirp_start; a captured sample is
//          readable from the FIFO one cycle after it is written.
// Backpressure: out_valid/out_ready; stalled bytes hold stable. When the FIFO is full,
//          incoming samples are dropped and the sticky overflow flag is set.
// Ports: clk, rst_n (sync, active-low); din/dvalid/din_en sample input; chirp_start trigger;
//        out_data/out_valid/out_ready byte stream; frame_active, frame_done, overflow status.
module fir_frame_packer #(
  parameter int         DATA_WIDTH        = 14,
  parameter int         SAMPLES_PER_FRAME = 1024,
  parameter int         SPF_LOG2          = 10,
  parameter int         FIFO_DEPTH        = 8,
  parameter int         FIFO_DEPTH_LOG2   = 3,
  parameter logic [7:0] START_FLAG        = 8'hA5,
  parameter logic [7:0] STOP_FLAG         = 8'h5A,
  parameter logic [7:0] STOP_FLAG_OVF     = 8'h5B
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         dvalid,
  input  logic                         din_en,
  input  logic                         chirp_start,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         frame_active,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_SAMP_HI = 3'd2;
  localparam logic [2:0] S_SAMP_LO = 3'd3;
  localparam logic [2:0] S_FOOTER  = 3'd4;

  localparam logic [SPF_LOG2:0]        SPF_CNT   = SAMPLES_PER_FRAME[SPF_LOG2:0];
  localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL = FIFO_DEPTH[FIFO_DEPTH_LOG2:0];

  logic [2:0]                   state, state_nxt;
  logic [SPF_LOG2:0]            cap_cnt;
  logic                         ovf_q;

  logic [DATA_WIDTH-1:0]        mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]     fcnt;
  logic                         fifo_empty, fifo_full;
  logic signed [DATA_WIDTH-1:0] head;
  logic [7:0]                   head_hi, head_lo;

  logic samp, accept, cap_open, cap_done;
  logic push_req, push, pop, drop;

  assign samp       = dvalid && din_en;
  assign accept     = chirp_start && (state == S_IDLE);
  assign cap_done   = (cap_cnt == SPF_CNT);
  // The accept cycle opens capture even though cap_cnt still holds the
  // previous frame's saturated count.
  assign cap_open   = accept || ((state != S_IDLE) && (cap_cnt < SPF_CNT));

  assign fifo_empty = (fcnt == '0);
  assign fifo_full  = (fcnt == FIFO_FULL);
  assign head       = mem[rd_ptr];
  // Arithmetic shift sign-fills, so the low 8 bits are bits [DW-1:8] sign-extended.
  assign head_hi    = 8'(head >>> 8);
  assign head_lo    = head[7:0];

  // SAMP_LO is only entered with a non-empty FIFO, so out_valid is high there.
  assign pop        = (state == S_SAMP_LO) && out_ready;
  assign push_req   = cap_open && samp;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && !push;

  assign frame_active = (state != S_IDLE);
  assign frame_done   = (state == S_FOOTER) && out_ready;
  assign overflow     = ovf_q;

  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (chirp_start) state_nxt = S_HEADER;
      end
      S_HEADER: begin
        out_valid = 1'b1;
        out_data  = START_FLAG;
        if (out_ready) state_nxt = S_SAMP_HI;
      end
      S_SAMP_HI: begin
        if (!fifo_empty) begin
          out_valid = 1'b1;
          out_data  = head_hi;
          if (out_ready) state_nxt = S_SAMP_LO;
        end else if (cap_done) begin
          state_nxt = S_FOOTER;
        end
      end
      S_SAMP_LO: begin
        out_valid = 1'b1;
        out_data  = head_lo;
        if (out_ready) state_nxt = S_SAMP_HI;
      end
      S_FOOTER: begin
        out_valid = 1'b1;
        out_data  = ovf_q ? STOP_FLAG_OVF : STOP_FLAG;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cap_cnt <= '0;
      ovf_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fcnt    <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        cap_cnt <= samp ? {{SPF_LOG2{1'b0}}, 1'b1} : '0;
      end else if (push_req) begin
        cap_cnt <= cap_cnt + 1'b1;
      end

      // The FIFO is always empty in IDLE, so accept and drop never coincide.
      if (accept)    ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by fcnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule
